// File: rtl/pcm_audio_pkg.sv
// pcm_audio_pkg: shared constants for the PCM audio output path.
//   - default slot width and bit-clock divider
//   - word-select channel encoding
//   - silence bit used to fill frames when no sample is available
package pcm_audio_pkg;

  localparam int   PCM_DATA_W_DEF  = 16;
  localparam int   PCM_CLK_DIV_DEF = 4;

  localparam logic WS_LEFT  = 1'b0;
  localparam logic WS_RIGHT = 1'b1;

  localparam logic PCM_SILENCE_BIT = 1'b0;

endpackage

// File: rtl/pcm_sck_gen.sv
// pcm_sck_gen: divides the system clock down to the I2S bit clock.
//   clk, reset : system clock, asynchronous active-low reset
//   sck        : bit clock, low out of reset, toggles every CLK_DIV clk cycles
//   fall_tick  : one-clk strobe, high during the cycle whose edge drives sck low
module pcm_sck_gen
  import pcm_audio_pkg::*;
#(
  parameter int CLK_DIV = PCM_CLK_DIV_DEF
) (
  input  logic clk,
  input  logic reset,
  output logic sck,
  output logic fall_tick
);

  localparam int            CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic          sck_q, sck_d;
  logic          wrap;

  always_comb begin
    wrap      = (div_cnt_q == DIV_LAST);
    div_cnt_d = wrap ? '0 : div_cnt_q + CW'(1);
    sck_d     = wrap ? ~sck_q : sck_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt_q <= '0;
      sck_q     <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      sck_q     <= sck_d;
    end
  end

  assign sck       = sck_q;
  // A wrap while sck is high is the edge that takes sck low.
  assign fall_tick = wrap & sck_q;

endmodule

// File: rtl/pcm_i2s_tx.sv
// pcm_i2s_tx: stereo PCM to I2S transmitter with a one-sample holding register.
//   clk, reset        : system clock, asynchronous active-low reset
//   sample_l/sample_r : PCM pair, accepted on sample_valid && sample_ready
//   sample_ready      : holding register empty
//   underrun_clr      : clears the sticky underrun flag (a coincident set wins)
//   sck, ws, sd       : I2S bit clock, word select (0 = left), serial data MSB first
//   underrun          : sticky, set when a frame starts with no sample buffered
// Build option: define PCM_TX_LJ_EN for left-justified word select (ws changes
// with the MSB instead of one bit ahead of it).
module pcm_i2s_tx
  import pcm_audio_pkg::*;
#(
  parameter int DATA_W  = PCM_DATA_W_DEF,
  parameter int CLK_DIV = PCM_CLK_DIV_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] sample_l,
  input  logic [DATA_W-1:0] sample_r,
  input  logic              sample_valid,
  output logic              sample_ready,
  input  logic              underrun_clr,
  output logic              sck,
  output logic              ws,
  output logic              sd,
  output logic              underrun
);

  localparam int            FRAME_W  = 2 * DATA_W;
  localparam int            BW       = $clog2(FRAME_W);
  localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_W - 1);
  localparam logic [BW-1:0] HALF     = BW'(DATA_W);

  logic               fall_tick;
  logic               frame_load;
  logic               wr_en;
  logic [BW-1:0]      ws_cnt;

  logic [BW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0]  hold_l_q, hold_l_d;
  logic [DATA_W-1:0]  hold_r_q, hold_r_d;
  logic               hold_full_q, hold_full_d;
  logic               underrun_q, underrun_d;
  logic               ws_q, ws_d;

  pcm_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
    .clk       (clk),
    .reset     (reset),
    .sck       (sck),
    .fall_tick (fall_tick)
  );

  always_comb begin
    frame_load  = fall_tick && (bit_cnt_q == BIT_LAST);
    // Load and write look at the same pre-edge hold_full_q, so a write landing
    // on the load edge goes out one frame later (no bypass).
    wr_en       = sample_valid && !hold_full_q;

    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    hold_full_d = hold_full_q;
    underrun_d  = underrun_q;
    ws_d        = ws_q;

    if (fall_tick) begin
      bit_cnt_d = frame_load ? '0 : bit_cnt_q + BW'(1);
      shift_d   = {shift_q[FRAME_W-2:0], PCM_SILENCE_BIT};
    end

`ifdef PCM_TX_LJ_EN
    ws_cnt = bit_cnt_d;
`else
    // I2S: ws reflects the bit after the one being sent, giving the one-bit lead.
    ws_cnt = (bit_cnt_d == BIT_LAST) ? '0 : bit_cnt_d + BW'(1);
`endif
    if (fall_tick)
      ws_d = (ws_cnt >= HALF) ? WS_RIGHT : WS_LEFT;

    if (underrun_clr)
      underrun_d = 1'b0;

    if (frame_load) begin
      if (hold_full_q) begin
        shift_d     = {hold_l_q, hold_r_q};
        hold_full_d = 1'b0;
      end else begin
        shift_d     = {FRAME_W{PCM_SILENCE_BIT}};
        underrun_d  = 1'b1;
      end
    end

    if (wr_en) begin
      hold_l_d    = sample_l;
      hold_r_d    = sample_r;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      hold_full_q <= 1'b0;
      underrun_q  <= 1'b0;
      ws_q        <= WS_LEFT;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      hold_full_q <= hold_full_d;
      underrun_q  <= underrun_d;
      ws_q        <= ws_d;
    end
  end

  assign sd           = shift_q[FRAME_W-1];
  assign ws           = ws_q;
  assign underrun     = underrun_q;
  assign sample_ready = ~hold_full_q;

endmodule

// File: doc/pcm_i2s_tx.md
Name: pcm_i2s_tx

Overview:
- Audio output transmitter: the playback-side counterpart of the microphone capture path.
- Accepts parallel stereo PCM samples (left/right) over a valid/ready handshake and serialises them as an I2S stream (sck, ws, sd) to an external DAC/amplifier.
- Generates its own bit clock from the system clock.
- Buffers one stereo sample and flags underrun when no sample is available at a frame boundary.

Parameters:
- DATA_W, 16: bits per channel slot; frame = 2*DATA_W sck periods.
- CLK_DIV, 4: clk cycles per sck half-period (>=1); sck period = 2*CLK_DIV clk cycles.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- sample_l  in  DATA_W  left PCM sample, two's complement.
- sample_r  in  DATA_W  right PCM sample, two's complement.
- sample_valid  in  1  sample pair valid.
- sample_ready  out  1  holding register empty; a transfer occurs when valid && ready on a clk edge.
- underrun_clr  in  1  clears the sticky underrun flag.
- sck  out  1  I2S bit clock.
- ws  out  1  word select; 0 = left, 1 = right.
- sd  out  1  serial data, MSB first.
- underrun  out  1  sticky underrun flag.

Behaviour:
- Reset (async, while reset=0): sck=0, ws=0, sd=0, underrun=0, div_cnt=0, bit_cnt=0, shift register=0, holding empty (sample_ready=1 once reset releases). Reset mid-frame aborts the frame immediately; the holding contents are discarded.
- Divider: div_cnt counts 0..CLK_DIV-1. At CLK_DIV-1 it wraps and sck toggles.
  - fall_tick = wrap while sck=1.
  - All serial state updates on fall_tick, in the same clk edge that drives sck low. sd and ws are therefore stable for the DAC's rising-edge sample.
- bit_cnt counts 0..2*DATA_W-1, increments each fall_tick and wraps to 0.
- sd per bit_cnt:
  - bit_cnt 0..DATA_W-1: left[DATA_W-1-bit_cnt].
  - bit_cnt DATA_W..2*DATA_W-1: right[2*DATA_W-1-bit_cnt].
  - Implemented as a 2*DATA_W shift register {L,R} shifted left each fall_tick.
- ws (standard I2S, one-bit lead): ws = ((bit_cnt+1) mod 2*DATA_W) >= DATA_W. ws therefore changes one sck period before each MSB.
- Frame load: on the fall_tick where bit_cnt wraps to 0:
  - Holding full: shift register <= {hold_l, hold_r}, holding emptied, sample_ready rises on the next clk.
  - Holding empty: shift register <= 0 (silence) and underrun <= 1.
- Frame 0 after reset transmits zeros and does not set underrun.
- Holding write: valid && ready loads hold_l/hold_r and sets full; sample_ready falls on the next clk.
- Simultaneous write and load in the same clk: the load sees the pre-write (empty) state, so the frame is silence with underrun set, and the written sample goes out in the following frame. There is no bypass path.
- underrun is sticky until underrun_clr=1. If a clear and a set coincide, set wins.
- sample_ready = !hold_full, driven directly from the register.

Optional Feature:
- PCM_TX_LJ_EN defined: left-justified format, ws = bit_cnt >= DATA_W, so ws changes coincident with the MSB (no one-bit lead).
- Undefined: standard I2S timing as above.
- Serial data ordering, load and underrun behaviour are identical in both modes.

Decomposition:
- Package pcm_audio_pkg holds:
  - the default DATA_W/CLK_DIV constants;
  - channel encoding constants (WS_LEFT=0, WS_RIGHT=1);
  - a silence constant.
- One sub-module, pcm_sck_gen: divider producing sck and the fall_tick strobe, with the same clk/reset ports.
- Holding register, counters and shift register stay in pcm_i2s_tx.

Test Plan (DATA_W=16, CLK_DIV=2, so 4 clk per sck and 128 clk per frame):
- Release reset, push L=16'hA5F0, R=16'h0F0F during frame 0 -> frame 0 sd all zeros with underrun=0. Frame 1 sd = 1010010111110000 then 0000111100001111. ws high from bit_cnt 15 to 30.
- Push no sample after frame 1 -> frame 2 sd all zeros and underrun=1 from the frame-2 load edge. Pulse underrun_clr -> underrun=0 the next clk.
- Two back-to-back pushes -> first accepted, sample_ready=0 until the next frame-load edge and back to 1 one clk later. The second sample is transmitted in the following frame.
- Assert reset mid-frame at bit_cnt=7 -> sck/ws/sd/underrun=0 immediately (async, no clk edge needed). After release the first frame is silent.
- Write with sample_valid at the exact frame-load clk -> that frame silent with underrun=1; the sample appears in the next frame.
- Build with PCM_TX_LJ_EN, push L=16'h8001 -> ws falls and sd=1 (MSB) on the same fall_tick at bit_cnt 0. ws rises exactly at bit_cnt 16.
